// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect arbiters: FSM encoding,
// width helpers and the default per-slave address slice.
package axi_ic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_DATA = 2'd3
  } rd_state_t;

  localparam logic [31:0] DEFAULT_SLICE_SIZE = 32'h0000_0080;

  // Index widths never collapse to zero so a single master/slave/ID still
  // has a usable select field.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int idw_of(input int num_outstanding);
    return clog2_min1(num_outstanding);
  endfunction

  function automatic int sw_of(input int num_slaves);
    return clog2_min1(num_slaves);
  endfunction

  function automatic int mw_of(input int num_masters);
    return clog2_min1(num_masters);
  endfunction

endpackage

// File: rtl/addr_decode.sv
// Maps a master address onto the slave index owning that address slice.
module addr_decode #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] SLICE_SIZE = 32'h0000_0080,
  parameter int          SW         = 1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [SW-1:0]         sel
);

  localparam logic [ADDR_WIDTH-1:0] SLICE = ADDR_WIDTH'(SLICE_SIZE);

  // Upper quotient bits wrap, so addresses beyond S slices alias back.
  assign sel = SW'(addr / SLICE);

endmodule

// File: rtl/read_slave_ctrl.sv
// Per-slave read control: round-robin AR pick, address handshake, wait for
// the R burst and hold the route until R_last transfers.
module read_slave_ctrl
  import axi_ic_pkg::*;
#(
  parameter int M   = 2,
  parameter int MW  = 1,
  parameter int IDW = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [M-1:0]     ar_elig,
  input  logic [M-1:0]     ar_valid,
  input  logic [M*IDW-1:0] ar_id,
  input  logic             r_go,
  input  logic             r_valid,
  input  logic             r_ready,
  input  logic             r_last,
  output rd_state_t        state,
  output logic [MW-1:0]    owner,
  output logic [IDW-1:0]   own_id,
  output logic             slot_set,
  output logic             slot_clr
);

  rd_state_t      state_reg;
  logic [MW-1:0]  ptr_reg;
  logic [MW-1:0]  owner_reg;
  logic [IDW-1:0] own_id_reg;

  logic           pick_found;
  logic [MW-1:0]  pick_idx;

  // First eligible master scanning upward from ptr, wrapping at M.
  always_comb begin
    int cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < M; k++) begin
      cand = (int'(ptr_reg) + k) % M;
      if (!pick_found && ar_elig[cand]) begin
        pick_found = 1'b1;
        pick_idx   = MW'(cand);
      end
    end
  end

  assign slot_set = (state_reg == ST_ADDR) && ar_valid[owner_reg];
  assign slot_clr = (state_reg == ST_DATA) && r_valid && r_ready && r_last;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= '0;
      owner_reg  <= '0;
      own_id_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_found) begin
            owner_reg  <= pick_idx;
            own_id_reg <= ar_id[pick_idx*IDW +: IDW];
            state_reg  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // A master that withdrew AR during its grant cycle leaves no record.
          if (ar_valid[owner_reg]) begin
            ptr_reg   <= (owner_reg == MW'(M-1)) ? '0 : owner_reg + 1'b1;
            state_reg <= ST_WAIT;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (r_go) state_reg <= ST_DATA;
        end
        ST_DATA: begin
          if (r_valid && r_ready && r_last) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign state  = state_reg;
  assign owner  = owner_reg;
  assign own_id = own_id_reg;

endmodule

// File: rtl/read_arbiter.sv
// AXI read-path arbiter: AR decode and per-slave round-robin, outstanding
// read table per master/ID, and R-burst routing back to the issuing master.
module read_arbiter
  import axi_ic_pkg::*;
#(
  parameter int          M                     = 2,
  parameter int          S                     = 2,
  parameter int          NUM_OUTSTANDING_TRANS = 2,
  parameter int          ADDR_WIDTH            = 32,
  parameter logic [31:0] SLICE_SIZE            = DEFAULT_SLICE_SIZE,
  localparam int         IDW                   = idw_of(NUM_OUTSTANDING_TRANS),
  localparam int         SW                    = sw_of(S),
  localparam int         MW                    = mw_of(M)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [M-1:0]          AR_valid_f,
  input  logic [M*ADDR_WIDTH-1:0] AR_addr_f,
  input  logic [M*IDW-1:0]      AR_id_f,
  output logic [M-1:0]          AR_grant_f,
  output logic [M*SW-1:0]       AR_sel_f,
  input  logic [M-1:0]          R_ready_f,
  input  logic [S-1:0]          R_valid_f,
  input  logic [S-1:0]          R_last_f,
  output logic [M-1:0]          R_grant_f,
  output logic [M*SW-1:0]       R_sel_f,
  output logic [S-1:0]          RS_grant_f,
  output logic [S*MW-1:0]       RS_sel_f
);

  logic [SW-1:0]                    ar_sel [M];
  logic [NUM_OUTSTANDING_TRANS-1:0] slot_vld_reg [M];
  logic [M-1:0]                     elig [S];
  rd_state_t                        st [S];
  logic [MW-1:0]                    own [S];
  logic [IDW-1:0]                   oid [S];
  logic [S-1:0]                     slot_set;
  logic [S-1:0]                     slot_clr;
  logic [S-1:0]                     r_claim;
  logic [S-1:0]                     r_go;
  logic [M-1:0]                     port_busy;

  genvar gi;

  for (gi = 0; gi < M; gi++) begin : g_dec
    addr_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .SLICE_SIZE (SLICE_SIZE),
      .SW         (SW)
    ) u_dec (
      .addr (AR_addr_f[gi*ADDR_WIDTH +: ADDR_WIDTH]),
      .sel  (ar_sel[gi])
    );
    assign AR_sel_f[gi*SW +: SW] = ar_sel[gi];
  end

  // A master with its AR ID already in flight is held off every slave.
  always_comb begin
    for (int s = 0; s < S; s++) begin
      elig[s] = '0;
      for (int m = 0; m < M; m++) begin
        elig[s][m] = AR_valid_f[m] && (ar_sel[m] == SW'(s)) &&
                     !slot_vld_reg[m][AR_id_f[m*IDW +: IDW]];
      end
    end
  end

  always_comb begin
    port_busy = '0;
    for (int s = 0; s < S; s++) begin
      if (st[s] == ST_DATA) port_busy[own[s]] = 1'b1;
    end
  end

  // Several slaves may want the same free master port at once; the lowest
  // slave index takes it and the others retry next cycle.
  always_comb begin
    r_claim = '0;
    r_go    = '0;
    for (int s = 0; s < S; s++) begin
      r_claim[s] = (st[s] == ST_WAIT) && R_valid_f[s] && !port_busy[own[s]];
    end
    for (int s = 0; s < S; s++) begin
      r_go[s] = r_claim[s];
      for (int j = 0; j < s; j++) begin
        if (r_claim[j] && (own[j] == own[s])) r_go[s] = 1'b0;
      end
    end
  end

  for (gi = 0; gi < S; gi++) begin : g_slv
    read_slave_ctrl #(
      .M   (M),
      .MW  (MW),
      .IDW (IDW)
    ) u_ctrl (
      .clk      (clk),
      .clr      (clr),
      .ar_elig  (elig[gi]),
      .ar_valid (AR_valid_f),
      .ar_id    (AR_id_f),
      .r_go     (r_go[gi]),
      .r_valid  (R_valid_f[gi]),
      .r_ready  (R_ready_f[own[gi]]),
      .r_last   (R_last_f[gi]),
      .state    (st[gi]),
      .owner    (own[gi]),
      .own_id   (oid[gi]),
      .slot_set (slot_set[gi]),
      .slot_clr (slot_clr[gi])
    );
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int m = 0; m < M; m++) slot_vld_reg[m] <= '0;
    end else begin
      for (int s = 0; s < S; s++) begin
        if (slot_clr[s]) slot_vld_reg[own[s]][oid[s]] <= 1'b0;
        if (slot_set[s]) slot_vld_reg[own[s]][oid[s]] <= 1'b1;
      end
    end
  end

  // Grants and selects decode registered state only.
  always_comb begin
    AR_grant_f = '0;
    R_grant_f  = '0;
    R_sel_f    = '0;
    RS_grant_f = '0;
    RS_sel_f   = '0;
    for (int s = 0; s < S; s++) begin
      if (st[s] == ST_ADDR) AR_grant_f[own[s]] = 1'b1;
      if (st[s] == ST_DATA) begin
        RS_grant_f[s]              = 1'b1;
        RS_sel_f[s*MW +: MW]       = own[s];
        R_grant_f[own[s]]          = 1'b1;
        R_sel_f[own[s]*SW +: SW]   = SW'(s);
      end
    end
  end

endmodule

// File: tb/tb_read_arbiter.sv
// Directed test-plan steps followed by random single-issuer traffic checked
// against a transaction-level model of slave occupancy and ID slots.
module tb_read_arbiter;

  localparam int          M     = 2;
  localparam int          S     = 2;
  localparam int          AW    = 32;
  localparam logic [31:0] SLICE = 32'h0000_0080;

  logic            clk = 1'b0;
  logic            clr;
  logic [M-1:0]    ar_valid;
  logic [M*AW-1:0] ar_addr;
  logic [M-1:0]    ar_id;
  logic [M-1:0]    ar_grant;
  logic [M-1:0]    ar_sel;
  logic [M-1:0]    r_ready;
  logic [S-1:0]    r_valid;
  logic [S-1:0]    r_last;
  logic [M-1:0]    r_grant;
  logic [M-1:0]    r_sel;
  logic [S-1:0]    rs_grant;
  logic [S-1:0]    rs_sel;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which slave is occupied by which master, and which
  // master/ID pairs are in flight.
  bit bs_busy [S];
  int bs_own  [S];
  int bs_id   [S];
  bit slot_m  [M][2];

  always #5 clk = ~clk;

  read_arbiter #(
    .M(M), .S(S), .NUM_OUTSTANDING_TRANS(2), .ADDR_WIDTH(AW), .SLICE_SIZE(SLICE)
  ) dut (
    .clk(clk), .clr(clr),
    .AR_valid_f(ar_valid), .AR_addr_f(ar_addr), .AR_id_f(ar_id),
    .AR_grant_f(ar_grant), .AR_sel_f(ar_sel),
    .R_ready_f(r_ready), .R_valid_f(r_valid), .R_last_f(r_last),
    .R_grant_f(r_grant), .R_sel_f(r_sel),
    .RS_grant_f(rs_grant), .RS_sel_f(rs_sel)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ar(input int m, input logic v, input logic [31:0] a, input logic id);
    ar_valid[m]          = v;
    ar_addr[m*AW +: AW]  = a;
    ar_id[m]             = id;
  endtask

  // Present one AR for two cycles; a grant, if any, must appear in cycle 1.
  task automatic issue(input int m, input logic [31:0] a, input logic id,
                       input logic exp_g, input string tag);
    set_ar(m, 1'b1, a, id);
    #1;
    chk({tag, "_sel"}, 32'(ar_sel[m]), (a / SLICE) % S);
    tick();
    chk({tag, "_grant"}, 32'(ar_grant[m]), 32'(exp_g));
    tick();
    set_ar(m, 1'b0, 32'h0, 1'b0);
    $display("txn ar m=%0d addr=%08h id=%0d granted=%0d", m, a, id, exp_g);
  endtask

  // Slave s (waiting, owned by m) returns a burst; optional stall on R_last.
  task automatic burst(input int s, input int m, input int beats, input bit stall,
                       input string tag);
    r_valid[s] = 1'b1;
    r_last[s]  = 1'b0;
    r_ready[m] = 1'b1;
    tick();
    chk({tag, "_route"}, {30'd0, rs_grant[s], r_grant[m]}, 32'h3);
    chk({tag, "_rs_sel"}, 32'(rs_sel[s]), m);
    chk({tag, "_r_sel"}, 32'(r_sel[m]), s);
    for (int b = 1; b <= beats; b++) begin
      r_last[s] = (b == beats);
      if (stall && b == beats) begin
        r_ready[m] = 1'b0;
        tick();
        chk({tag, "_stall"}, {30'd0, rs_grant[s], r_grant[m]}, 32'h3);
        r_ready[m] = 1'b1;
      end
      tick();
      if (b < beats) chk({tag, "_hold"}, {30'd0, rs_grant[s], r_grant[m]}, 32'h3);
    end
    r_valid[s] = 1'b0;
    r_last[s]  = 1'b0;
    chk({tag, "_done"}, {30'd0, rs_grant[s], r_grant[m]}, 32'h0);
    $display("txn r s=%0d m=%0d beats=%0d stall=%0d", s, m, beats, stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, s, id, beats;
    logic [31:0] a;
    logic exp_g;

    clr      = 1'b1;
    ar_valid = '0;
    ar_addr  = '0;
    ar_id    = '0;
    r_ready  = '1;
    r_valid  = '0;
    r_last   = '0;
    set_ar(1, 1'b0, 32'h80, 1'b0);
    tick();
    tick();
    chk("rst_ar_grant", 32'(ar_grant), 0);
    chk("rst_r_grant", 32'(r_grant), 0);
    chk("rst_r_sel", 32'(r_sel), 0);
    chk("rst_rs_grant", 32'(rs_grant), 0);
    chk("rst_rs_sel", 32'(rs_sel), 0);
    chk("rst_ar_sel_decode", 32'(ar_sel), 32'h2);
    clr = 1'b0;
    tick();

    // Single read with a stalled R_last, then reuse of the freed slot.
    issue(0, 32'h40, 1'b0, 1'b1, "single_ar");
    burst(0, 0, 4, 1'b1, "single_r");
    issue(0, 32'h40, 1'b0, 1'b1, "reuse_ar");
    burst(0, 0, 1, 1'b0, "reuse_r");

    // Contention on slave1: M0 first, M1 after M0's burst completes.
    set_ar(0, 1'b1, 32'h80, 1'b0);
    set_ar(1, 1'b1, 32'h80, 1'b0);
    tick();
    chk("cont_first", 32'(ar_grant), 32'h1);
    tick();
    set_ar(0, 1'b0, 32'h0, 1'b0);
    chk("cont_wait0", 32'(ar_grant), 0);
    tick();
    chk("cont_wait1", 32'(ar_grant), 0);
    burst(1, 0, 2, 1'b0, "cont_r0");
    chk("cont_not_yet", 32'(ar_grant), 0);
    tick();
    chk("cont_second", 32'(ar_grant), 32'h2);
    tick();
    set_ar(1, 1'b0, 32'h0, 1'b0);
    burst(1, 1, 1, 1'b0, "cont_r1");

    // Parallel: different slaves grant in the same cycle.
    set_ar(0, 1'b1, 32'h00, 1'b0);
    set_ar(1, 1'b1, 32'h80, 1'b1);
    tick();
    chk("par_grant", 32'(ar_grant), 32'h3);
    tick();
    set_ar(0, 1'b0, 32'h0, 1'b0);
    set_ar(1, 1'b0, 32'h0, 1'b0);
    burst(0, 0, 1, 1'b0, "par_r0");
    burst(1, 1, 2, 1'b0, "par_r1");

    // ID full: id 1 blocked while in flight, id 0 accepted.
    issue(0, 32'h00, 1'b1, 1'b1, "idf_first");
    set_ar(0, 1'b1, 32'h80, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idf_blocked", 32'(ar_grant), 0);
    end
    set_ar(0, 1'b1, 32'h80, 1'b0);
    tick();
    chk("idf_other_id", 32'(ar_grant), 32'h1);
    tick();
    set_ar(0, 1'b0, 32'h0, 1'b0);

    // R port collision on M0: slave0 wins, slave1 follows after its R_last.
    r_valid = 2'b11;
    tick();
    chk("col_first", 32'(rs_grant), 32'h1);
    chk("col_first_sel", 32'(r_sel[0]), 0);
    tick();
    chk("col_hold", 32'(rs_grant), 32'h1);
    r_last[0] = 1'b1;
    tick();
    r_valid[0] = 1'b0;
    r_last[0]  = 1'b0;
    chk("col_gap", 32'(rs_grant), 0);
    tick();
    chk("col_second", 32'(rs_grant), 32'h2);
    chk("col_second_sel", 32'(r_sel[0]), 1);
    chk("col_second_rs_sel", 32'(rs_sel[1]), 0);
    chk("col_second_rg", 32'(r_grant), 32'h1);
    r_last[1] = 1'b1;
    tick();
    r_valid[1] = 1'b0;
    r_last[1]  = 1'b0;
    chk("col_done", 32'(rs_grant), 0);
    $display("txn collision m=0 slaves=0,1 done");

    // Reset mid-burst: outputs drop at once, the read is forgotten.
    issue(0, 32'h00, 1'b0, 1'b1, "mid_ar");
    r_valid[0] = 1'b1;
    tick();
    chk("mid_data", 32'(r_grant), 32'h1);
    clr = 1'b1;
    #1;
    chk("mid_rst_grants", {29'd0, ar_grant[0], r_grant[0], rs_grant[0]}, 0);
    chk("mid_rst_sels", {30'd0, r_sel[0], rs_sel[0]}, 0);
    r_valid[0] = 1'b0;
    tick();
    clr = 1'b0;
    issue(0, 32'h00, 1'b0, 1'b1, "post_rst_ar");
    burst(0, 0, 1, 1'b0, "post_rst_r");

    // Random single-issuer traffic against the occupancy model.
    for (int it = 0; it < 80; it++) begin
      s = -1;
      for (int k = 0; k < S; k++) if (bs_busy[k] && (s < 0 || $urandom_range(0, 1) == 1)) s = k;
      if (s < 0 || $urandom_range(0, 2) != 0) begin
        m  = $urandom_range(0, M - 1);
        a  = $urandom;
        id = $urandom_range(0, 1);
        s  = (a / SLICE) % S;
        exp_g = !bs_busy[s] && !slot_m[m][id];
        issue(m, a, id[0], exp_g, "rnd_ar");
        if (exp_g) begin
          bs_busy[s]    = 1'b1;
          bs_own[s]     = m;
          bs_id[s]      = id;
          slot_m[m][id] = 1'b1;
        end
      end else begin
        beats = $urandom_range(1, 4);
        burst(s, bs_own[s], beats, 1'($urandom_range(0, 1)), "rnd_r");
        bs_busy[s] = 1'b0;
        slot_m[bs_own[s]][bs_id[s]] = 1'b0;
      end
    end
    for (int k = 0; k < S; k++) begin
      if (bs_busy[k]) begin
        burst(k, bs_own[k], 2, 1'b0, "drain_r");
        bs_busy[k] = 1'b0;
        slot_m[bs_own[k]][bs_id[k]] = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
